// File: rtl/output_display.sv
`default_nettype none
// ============================================================================
// Module      : output_display
// Description : Output register of the 8-bit datapath. Latches the byte on
//               the shared bus when load is high, converts it to decimal
//               sequentially (shift-add-3, 8 steps), unsigned or two's
//               complement, and drives a 4-digit multiplexed 7-seg display.
// Ports       : clk          system clock, rising edge
//               rst_n        synchronous active-low reset
//               bus_in[7:0]  shared datapath bus
//               load         output-register load strobe (active high)
//               signed_mode  1 = treat the loaded byte as two's complement
//               out_value    latched raw byte
//               busy         decimal conversion in progress
//               seg[6:0]     active-high segments, seg[0]=a .. seg[6]=g
//               dig_sel[3:0] one-hot digit enable, bit 0 = ones digit
// Revision    : 1.0  initial release
// ============================================================================
module output_display #(
    parameter int CLK_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] bus_in,
    input  logic       load,
    input  logic       signed_mode,
    output logic [7:0] out_value,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] dig_sel
);

    localparam int                   c_PRESC_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(CLK_DIV - 1);

    localparam logic [6:0] c_SEG_BLANK = 7'h00;
    localparam logic [6:0] c_SEG_MINUS = 7'h40;
    localparam logic [6:0] c_SEG_ZERO  = 7'h3F;

    // ------------------------------------------------------------------------
    // Digit to segment code
    // ------------------------------------------------------------------------
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [7:0]           r_out_value;
    logic                 r_busy;
    logic                 r_neg;        // sign of the value being converted
    logic [7:0]           r_mag;        // magnitude, shifted out MSB first
    logic [11:0]          r_bcd;        // hundreds/tens/ones accumulator
    logic [3:0]           r_steps;      // shift-add-3 steps still to do
    logic [3:0][6:0]      r_disp;       // committed segment codes per digit
    logic [c_PRESC_W-1:0] r_presc;
    logic [1:0]           r_idx;

    logic [11:0] w_bcd_adj;
    logic [11:0] w_bcd_shift;
    logic [7:0]  w_load_mag;
    logic        w_last_step;
    logic [3:0]  w_hund;
    logic [3:0]  w_tens;
    logic [3:0]  w_ones;

    // ------------------------------------------------------------------------
    // One shift-add-3 step: correct each nibble >= 5, then shift in mag MSB
    // ------------------------------------------------------------------------
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 3; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign w_bcd_shift = {w_bcd_adj[10:0], r_mag[7]};
    assign w_last_step = r_busy && (r_steps == 4'd1);

    // Negating 0x80 yields 0x80, which read unsigned is the wanted 128.
    assign w_load_mag  = (signed_mode && bus_in[7]) ? (~bus_in + 8'd1) : bus_in;

    // Final digits as they will exist after the last step
    assign w_hund = w_bcd_shift[11:8];
    assign w_tens = w_bcd_shift[7:4];
    assign w_ones = w_bcd_shift[3:0];

    // ------------------------------------------------------------------------
    // Load, conversion and atomic display commit
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_value <= 8'h00;
            r_busy      <= 1'b0;
            r_neg       <= 1'b0;
            r_mag       <= 8'h00;
            r_bcd       <= 12'h000;
            r_steps     <= 4'd0;
            r_disp[0]   <= c_SEG_ZERO;
            r_disp[1]   <= c_SEG_BLANK;
            r_disp[2]   <= c_SEG_BLANK;
            r_disp[3]   <= c_SEG_BLANK;
        end else if (load) begin
            // A load always restarts the conversion, even mid-flight.
            r_out_value <= bus_in;
            r_neg       <= signed_mode && bus_in[7];
            r_mag       <= w_load_mag;
            r_bcd       <= 12'h000;
            r_steps     <= 4'd8;
            r_busy      <= 1'b1;
        end else if (r_busy) begin
            r_mag   <= {r_mag[6:0], 1'b0};
            r_bcd   <= w_bcd_shift;
            r_steps <= r_steps - 4'd1;
            if (w_last_step) begin
                r_busy    <= 1'b0;
                r_disp[0] <= seg_code(w_ones);
                r_disp[1] <= ((w_hund == 4'd0) && (w_tens == 4'd0)) ? c_SEG_BLANK
                                                                    : seg_code(w_tens);
                r_disp[2] <= (w_hund == 4'd0) ? c_SEG_BLANK : seg_code(w_hund);
                r_disp[3] <= r_neg ? c_SEG_MINUS : c_SEG_BLANK;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Digit scan, free running
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= 2'd0;
        end else if (r_presc == c_PRESC_MAX) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Outputs are decoded from registers only.
    assign out_value = r_out_value;
    assign busy      = r_busy;
    assign dig_sel   = 4'b0001 << r_idx;
    assign seg       = r_disp[r_idx];

endmodule
`default_nettype wire
